// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 tables, GF helpers, FSM encoding and block type
package aes_pkg;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Byte b lives at bits [8*(255-b) +: 8], so the table reads left to right
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] lo;
        lo = {~b, 3'b000};
        return SBOX_TABLE[lo +: 8];
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] get_rcon(input logic [3:0] rnd);
        if (rnd >= 4'd1 && rnd <= 4'd10) begin
            return RCON[rnd];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/aes_keygen_step.sv
// rtl/aes_keygen_step.sv - one AES-128 key-expansion step: RotWord, SubWord, XOR chain
module aes_keygen_step
    import aes_pkg::*;
(
    input  block_t     rk,
    input  logic [7:0] rcon,
    output block_t     next_rk
);
    logic [31:0] w_rot;
    logic [31:0] w_temp;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign w_rot  = {rk[23:0], rk[31:24]};
    assign w_temp = {sbox(w_rot[31:24]) ^ rcon, sbox(w_rot[23:16]),
                     sbox(w_rot[15:8]), sbox(w_rot[7:0])};
    assign w_n0 = rk[127:96] ^ w_temp;
    assign w_n1 = rk[95:64] ^ w_n0;
    assign w_n2 = rk[63:32] ^ w_n1;
    assign w_n3 = rk[31:0] ^ w_n2;
    assign next_rk = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/encrypt_round.sv
// rtl/encrypt_round.sv - combinational AES round: SubBytes, ShiftRows, MixColumns, AddRoundKey
module encrypt_round
    import aes_pkg::*;
(
    input  block_t state_in,
    input  block_t round_key,
    input  logic   is_final_round,
    output block_t state_out
);
    logic [7:0] w_sr [16];
    block_t     w_shift;
    block_t     w_mix;

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            // ShiftRows: row r of column c comes from column (c+r) mod 4
            localparam int SRC = 4 * ((c + r) % 4) + r;
            assign w_sr[4*c+r] = sbox(state_in[127-8*SRC -: 8]);
            assign w_shift[127-8*(4*c+r) -: 8] = w_sr[4*c+r];
        end
        assign w_mix[127-32*c -: 32] = {
            gmul2(w_sr[4*c]) ^ gmul2(w_sr[4*c+1]) ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ w_sr[4*c+3],
            w_sr[4*c] ^ gmul2(w_sr[4*c+1]) ^ gmul2(w_sr[4*c+2]) ^ w_sr[4*c+2] ^ w_sr[4*c+3],
            w_sr[4*c] ^ w_sr[4*c+1] ^ gmul2(w_sr[4*c+2]) ^ gmul2(w_sr[4*c+3]) ^ w_sr[4*c+3],
            gmul2(w_sr[4*c]) ^ w_sr[4*c] ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ gmul2(w_sr[4*c+3])
        };
    end

    assign state_out = (is_final_round ? w_shift : w_mix) ^ round_key;

endmodule

// File: rtl/aes128_enc_iter.sv
// rtl/aes128_enc_iter.sv - iterative handshaked AES-128 encryptor, ROUNDS_PER_CYCLE rounds per clock
module aes128_enc_iter
    import aes_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy
);
    localparam int         NCYC     = 10 / ROUNDS_PER_CYCLE;
    localparam logic [3:0] LAST_RND = 4'(1 + (NCYC - 1) * ROUNDS_PER_CYCLE);
    localparam logic [3:0] RND_STEP = 4'(ROUNDS_PER_CYCLE);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
        ROUNDS_PER_CYCLE != 5 && ROUNDS_PER_CYCLE != 10) begin : g_bad_rpc
        $error("aes128_enc_iter: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end

    state_e     r_state;
    state_e     w_next;
    block_t     r_blk;
    block_t     r_rk;
    block_t     r_ct;
    logic [3:0] r_rnd;
    logic       w_accept;
    logic       w_last;
    block_t     w_blk_next;
    block_t     w_rk_next;

    // Unrolled round chain; key expansion runs alongside so no key schedule is stored
    for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_round
        block_t     w_st_in;
        block_t     w_rk_in;
        block_t     w_st_out;
        block_t     w_rk_out;
        logic [3:0] w_j;

        if (k == 0) begin : g_first
            assign w_st_in = r_blk;
            assign w_rk_in = r_rk;
        end else begin : g_next
            assign w_st_in = g_round[k-1].w_st_out;
            assign w_rk_in = g_round[k-1].w_rk_out;
        end

        assign w_j = r_rnd + 4'(k);

        aes_keygen_step u_keygen (
            .rk      (w_rk_in),
            .rcon    (get_rcon(w_j)),
            .next_rk (w_rk_out)
        );

        encrypt_round u_round (
            .state_in       (w_st_in),
            .round_key      (w_rk_out),
            .is_final_round (w_j == 4'd10),
            .state_out      (w_st_out)
        );
    end

    assign w_blk_next = g_round[ROUNDS_PER_CYCLE-1].w_st_out;
    assign w_rk_next  = g_round[ROUNDS_PER_CYCLE-1].w_rk_out;
    assign w_last     = (r_state == RUN) && (r_rnd == LAST_RND);
    assign in_ready   = !rst && ((r_state == IDLE) || (r_state == DONE && out_ready));
    assign w_accept   = in_valid && in_ready;
    assign out_valid  = (r_state == DONE);
    assign busy       = (r_state == RUN);
    assign ciphertext = r_ct;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    if (out_ready) w_next = in_valid ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_blk   <= '0;
            r_rk    <= '0;
            r_ct    <= '0;
            r_rnd   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_blk <= plaintext ^ key;
                r_rk  <= key;
                r_rnd <= 4'd1;
            end else if (r_state == RUN) begin
                r_blk <= w_blk_next;
                r_rk  <= w_rk_next;
                r_rnd <= w_last ? 4'd0 : r_rnd + RND_STEP;
                // Separate output register keeps a delivered result intact across a new accept
                if (w_last) begin
                    r_ct <= w_blk_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes128_enc_iter.sv
// tb/tb_aes128_enc_iter.sv - self-checking bench for aes128_enc_iter at all legal ROUNDS_PER_CYCLE
module tb_aes128_enc_iter;

    localparam int NDUT = 4;
    localparam int RPC_LIST [NDUT] = '{1, 2, 5, 10};

    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    int           sel;

    logic         ir_a   [NDUT];
    logic         ov_a   [NDUT];
    logic         busy_a [NDUT];
    logic [127:0] ct_a   [NDUT];

    int           n_checks;
    int           n_errors;
    logic [7:0]   ref_sbox [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        aes128_enc_iter #(.ROUNDS_PER_CYCLE(RPC_LIST[g])) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid && (sel == g)),
            .in_ready   (ir_a[g]),
            .plaintext  (plaintext),
            .key        (key),
            .out_valid  (ov_a[g]),
            .out_ready  (out_ready),
            .ciphertext (ct_a[g]),
            .busy       (busy_a[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s rpc=%0d: got %h expected %h", tag, RPC_LIST[sel], got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map
    task automatic build_sbox();
        logic [7:0] inv, s, v;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ 8'h63;
            v = inv;
            for (int r = 0; r < 4; r++) begin
                v = {v[6:0], v[7]};
                s = s ^ v;
            end
            ref_sbox[x] = s;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k_in);
        logic [7:0]   s [16];
        logic [7:0]   k [16];
        logic [7:0]   t [16];
        logic [7:0]   tmp [4];
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            k[i] = k_in[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ k[i];
        end
        rc = 8'h01;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            tmp[0] = ref_sbox[k[13]] ^ rc;
            tmp[1] = ref_sbox[k[14]];
            tmp[2] = ref_sbox[k[15]];
            tmp[3] = ref_sbox[k[12]];
            for (int i = 0; i < 16; i++) begin
                if (i < 4) k[i] = k[i] ^ tmp[i];
                else       k[i] = k[i] ^ k[i-4];
            end
            rc = gm(rc, 8'h02);
            for (int i = 0; i < 16; i++) s[i] = ref_sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    s[4*c]   = gm(t[4*c], 2) ^ gm(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 2) ^ gm(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 2) ^ gm(t[4*c+3], 3);
                    s[4*c+3] = gm(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 2);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_block(input int d, input logic [127:0] pt, input logic [127:0] k,
                             input logic [127:0] exp, input int hold, input bit toggle);
        int           lat;
        logic [127:0] held;
        sel       = d;
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        check("in_ready_idle", ir_a[d], 1'b1);
        tick();
        in_valid = 1'b0;
        check("busy_run", busy_a[d], 1'b1);
        check("valid_run", ov_a[d], 1'b0);
        lat = 0;
        while (!ov_a[d] && lat < 40) begin
            if (toggle) begin
                plaintext = rand128();
                key       = rand128();
            end
            tick();
            lat++;
        end
        check("latency", lat, 10 / RPC_LIST[d]);
        check("ciphertext", ct_a[d], exp);
        held = ct_a[d];
        for (int i = 0; i < hold; i++) begin
            if (toggle) begin
                plaintext = rand128();
                key       = rand128();
            end
            tick();
            check("hold_ct", ct_a[d], held);
            check("hold_valid", ov_a[d], 1'b1);
            check("hold_in_ready", ir_a[d], 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check("in_ready_deliver", ir_a[d], 1'b1);
        tick();
        out_ready = 1'b0;
        check("valid_after_deliver", ov_a[d], 1'b0);
        check("busy_after_deliver", busy_a[d], 1'b0);
    endtask

    task automatic back_to_back(input int d);
        logic [127:0] vp [4];
        logic [127:0] vk [4];
        logic [127:0] ve [4];
        int           cnt;
        for (int b = 0; b < 4; b++) begin
            vp[b] = (b % 2 == 0) ? PT_A : PT_B;
            vk[b] = (b % 2 == 0) ? KEY_A : KEY_B;
            ve[b] = (b % 2 == 0) ? CT_A : CT_B;
        end
        sel       = d;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        plaintext = vp[0];
        key       = vk[0];
        tick();
        for (int b = 0; b < 4; b++) begin
            if (b < 3) begin
                plaintext = vp[b+1];
                key       = vk[b+1];
            end else begin
                in_valid = 1'b0;
            end
            cnt = 0;
            while (!ov_a[d] && cnt < 40) begin
                tick();
                cnt++;
            end
            check("b2b_latency", cnt, 10 / RPC_LIST[d]);
            check("b2b_ct", ct_a[d], ve[b]);
            tick();
            check("b2b_valid_fall", ov_a[d], 1'b0);
            check("b2b_busy", busy_a[d], (b < 3) ? 1'b1 : 1'b0);
        end
        check("b2b_end_in_ready", ir_a[d], 1'b1);
        out_ready = 1'b0;
    endtask

    task automatic reset_mid_run(input int d);
        int ncyc;
        int pre;
        bit seen;
        ncyc      = 10 / RPC_LIST[d];
        pre       = (ncyc > 3) ? 3 : 0;
        sel       = d;
        plaintext = PT_A;
        key       = KEY_A;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < pre; i++) tick();
        check("busy_before_rst", busy_a[d], 1'b1);
        rst = 1'b1;
        tick();
        check("rst_in_ready", ir_a[d], 1'b0);
        check("rst_valid", ov_a[d], 1'b0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", ir_a[d], 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ov_a[d]) seen = 1'b1;
        end
        check("aborted_no_valid", seen, 1'b0);
        run_block(d, PT_B, KEY_B, CT_B, 0, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pt, k;
        n_checks  = 0;
        n_errors  = 0;
        sel       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        plaintext = '0;
        key       = '0;
        build_sbox();
        tick();
        for (int d = 0; d < NDUT; d++) begin
            sel = d;
            check("reset_in_ready", ir_a[d], 1'b0);
            check("reset_valid", ov_a[d], 1'b0);
            check("reset_busy", busy_a[d], 1'b0);
            check("reset_ct", ct_a[d], '0);
        end
        rst = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            sel = d;
            check("in_ready_after_reset", ir_a[d], 1'b1);
        end
        for (int d = 0; d < NDUT; d++) begin
            run_block(d, PT_A, KEY_A, CT_A, 0, 1'b0);
            run_block(d, PT_B, KEY_B, CT_B, 0, 1'b0);
            run_block(d, '0, '0, CT_Z, 7, 1'b0);
            back_to_back(d);
            reset_mid_run(d);
            for (int n = 0; n < 3; n++) begin
                pt = rand128();
                k  = rand128();
                run_block(d, pt, k, aes_ref(pt, k), $urandom_range(0, 3), 1'b1);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
